vga_capture_rx: RTL and testbench

VGA_CAPTURE_RX -- requirements
Module: vga_capture_rx

---
 rtl/vga_capture_rx.sv | 228 ++++++++++++++++++++++
 tb/tb_vga_capture_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture_rx.sv
// VGA capture receiver: registers raw sync/colour pins, measures line and
// frame timing, locks onto a stable timing and emits active pixels with
// coordinates two clocks after the pins.
// Optional build macro FRAME_CRC_EN adds a per-frame CRC-16-CCITT over the
// emitted pixels; without it frame_crc and crc_valid are tied to 0.
// Ports:
//   clk, rst                 clock (one pixel per cycle), sync active-high reset
//   vga_hsync, vga_vsync     sync pins, polarity set by SYNC_NEG
//   vga_r, vga_g, vga_b      4-bit colour pins
//   pix_valid/x/y/rgb        captured active pixel, coordinates and {r,g,b}
//   pix_sof, pix_eol         first pixel of frame, last pixel of line
//   line_len, frame_lines    last measured clocks per line / lines per frame
//   locked, lost             in LOCKED state / one-cycle pulse on leaving it
//   frame_crc, crc_valid     per-frame CRC and its strobe
module vga_capture_rx #(
  parameter int unsigned H_START  = 144,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_START  = 35,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned SYNC_NEG = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic [11:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        locked,
  output logic        lost,
  output logic [15:0] frame_crc,
  output logic        crc_valid
);

  localparam logic [12:0] H_LO   = 13'(H_START);
  localparam logic [12:0] H_HI   = 13'(H_START + H_ACTIVE);
  localparam logic [11:0] H_LAST = 12'(H_START + H_ACTIVE - 1);
  localparam logic [10:0] V_LO   = 11'(V_START);
  localparam logic [10:0] V_HI   = 11'(V_START + V_ACTIVE);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t      state, state_next;
  logic        hs_act, vs_act, hs_q, vs_q, hs_prev, vs_prev, hs_edge, vs_edge;
  logic [11:0] rgb_q, h_reg, h_cnt, h_inc, ll_new;
  logic [9:0]  v_reg, v_cnt, v_inc;
  logic [11:0] prev_ll;
  logic [9:0]  prev_fl;
  logic        prev_ok, line_ok, first_line, line_ok_c, frame_match, timeout;
  logic        lost_d, locked_d, h_in, v_in, valid_d;

  assign hs_act = (SYNC_NEG != 0) ? ~vga_hsync : vga_hsync;
  assign vs_act = (SYNC_NEG != 0) ? ~vga_vsync : vga_vsync;

  // Input register; sync history starts "active" so a sync already asserted
  // at reset release is not taken as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      hs_prev <= 1'b1;
      vs_prev <= 1'b1;
      rgb_q   <= '0;
    end else begin
      hs_q    <= hs_act;
      vs_q    <= vs_act;
      hs_prev <= hs_q;
      vs_prev <= vs_q;
      rgb_q   <= {vga_r, vga_g, vga_b};
    end
  end

  assign hs_edge = hs_q & ~hs_prev;
  assign vs_edge = vs_q & ~vs_prev;

  // Counters are 0 in the assertion cycle itself; h_reg holds the saturated
  // successor, so at an hsync edge it already equals the finished line length.
  always_comb begin
    h_cnt = hs_edge ? 12'd0 : h_reg;
    h_inc = (h_cnt == 12'hFFF) ? h_cnt : h_cnt + 12'd1;
    v_inc = (v_reg == 10'h3FF) ? v_reg : v_reg + 10'd1;
    v_cnt = v_reg;
    if (vs_edge)      v_cnt = 10'd0;
    else if (hs_edge) v_cnt = v_inc;
  end

  // Frame consistency: every line after the first one of a frame must repeat
  // the previous line length; the previous frame must itself have been clean.
  always_comb begin
    ll_new      = hs_edge ? h_reg : line_len;
    line_ok_c   = line_ok & (~hs_edge | first_line | (h_reg == line_len));
    frame_match = line_ok_c & prev_ok & (ll_new == prev_ll) & (v_inc == prev_fl);
    timeout     = (h_cnt == 12'hFFF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_reg       <= '0;
      v_reg       <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      prev_ll     <= '0;
      prev_fl     <= '0;
      prev_ok     <= 1'b0;
      line_ok     <= 1'b1;
      first_line  <= 1'b1;
    end else begin
      h_reg <= h_inc;
      v_reg <= v_cnt;
      if (hs_edge) line_len <= h_reg;
      if (vs_edge) begin
        frame_lines <= v_inc;
        prev_ll     <= ll_new;
        prev_fl     <= v_inc;
        prev_ok     <= (state == SEARCH) ? 1'b0 : line_ok_c;
        line_ok     <= 1'b1;
        first_line  <= 1'b1;
      end else begin
        line_ok <= line_ok_c;
        if (hs_edge) first_line <= 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SEARCH;
      locked <= 1'b0;
      lost   <= 1'b0;
    end else begin
      state  <= state_next;
      locked <= locked_d;
      lost   <= lost_d;
    end
  end

  // Next-state logic; a missing hsync overrides everything
  always_comb begin
    state_next = state;
    case (state)
      SEARCH: if (vs_edge) state_next = TRACK;
      TRACK:  if (vs_edge && frame_match) state_next = LOCKED;
      LOCKED: if (vs_edge && !frame_match) state_next = TRACK;
      default: state_next = SEARCH;
    endcase
    if (timeout) state_next = SEARCH;
  end

  // Output decode
  always_comb begin
    locked_d = (state_next == LOCKED);
    lost_d   = (state == LOCKED) && (state_next != LOCKED);
  end

  // Pixel stage: second register level after the input register
  always_comb begin
    h_in    = ({1'b0, h_cnt} >= H_LO) && ({1'b0, h_cnt} < H_HI);
    v_in    = ({1'b0, v_cnt} >= V_LO) && ({1'b0, v_cnt} < V_HI);
    valid_d = h_in & v_in & (state == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst || !valid_d) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_rgb   <= '0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
    end else begin
      pix_valid <= 1'b1;
      pix_x     <= 10'(h_cnt - 12'(H_START));
      pix_y     <= v_cnt - 10'(V_START);
      pix_rgb   <= rgb_q;
      pix_sof   <= (h_cnt == 12'(H_START)) && (v_cnt == 10'(V_START));
      pix_eol   <= (h_cnt == H_LAST);
    end
  end

`ifdef FRAME_CRC_EN
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  logic [15:0] crc, crc_fold;
  logic        seen_lock;

  assign crc_fold = pix_valid ? crc_step(crc, pix_rgb) : crc;

  // Per-frame CRC; the strobe is only raised for frames that were locked
  always_ff @(posedge clk) begin
    if (rst) begin
      crc       <= 16'hFFFF;
      frame_crc <= 16'hFFFF;
      crc_valid <= 1'b0;
      seen_lock <= 1'b0;
    end else if (vs_edge) begin
      frame_crc <= crc_fold;
      crc       <= 16'hFFFF;
      crc_valid <= seen_lock | locked;
      seen_lock <= 1'b0;
    end else begin
      crc       <= crc_fold;
      crc_valid <= 1'b0;
      seen_lock <= seen_lock | locked;
    end
  end
`else
  assign frame_crc = '0;
  assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_capture_rx.sv
// Directed bench for vga_capture_rx using a shrunken timing (20-clk lines,
// 10-line frames, 8x4 active window). A second instance runs with
// active-high syncs on the same video.
module tb_vga_capture_rx;

  localparam int HS = 4, HA = 8, VS = 2, VA = 4, LL = 20, NL = 10;
`ifdef FRAME_CRC_EN
  localparam logic [15:0] CRC_RST = 16'hFFFF;
`else
  localparam logic [15:0] CRC_RST = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst;
  logic hsync_n, vsync_n, hsync_p, vsync_p;
  logic [3:0] r, g, b;

  logic        pix_valid, pix_sof, pix_eol, locked, lost, crc_valid;
  logic [9:0]  pix_x, pix_y, frame_lines;
  logic [11:0] pix_rgb, line_len;
  logic [15:0] frame_crc;

  logic        p_valid, p_sof, p_eol, p_locked, p_lost, p_crc_valid;
  logic [9:0]  p_x, p_y, p_frame_lines;
  logic [11:0] p_rgb, p_line_len;
  logic [15:0] p_frame_crc;

  vga_capture_rx #(.H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA), .SYNC_NEG(1)) dut (
    .clk(clk), .rst(rst), .vga_hsync(hsync_n), .vga_vsync(vsync_n),
    .vga_r(r), .vga_g(g), .vga_b(b),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .line_len(line_len), .frame_lines(frame_lines),
    .locked(locked), .lost(lost), .frame_crc(frame_crc), .crc_valid(crc_valid));

  vga_capture_rx #(.H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA), .SYNC_NEG(0)) dut_pos (
    .clk(clk), .rst(rst), .vga_hsync(hsync_p), .vga_vsync(vsync_p),
    .vga_r(r), .vga_g(g), .vga_b(b),
    .pix_valid(p_valid), .pix_x(p_x), .pix_y(p_y), .pix_rgb(p_rgb),
    .pix_sof(p_sof), .pix_eol(p_eol), .line_len(p_line_len), .frame_lines(p_frame_lines),
    .locked(p_locked), .lost(p_lost), .frame_crc(p_frame_crc), .crc_valid(p_crc_valid));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  int frame_no = 0;
  bit solid = 1'b0;
  int last_hs_cyc = 0, first_pix_cyc = 0;

  // Monitor: accumulates observations, checks each pixel against its index
  int mon_frame = -1, k = 0, mon_pix = 0, mon_bad = 0, lost_cnt = 0, crcv_cnt = 0;
  int lost_cyc = 0, sof_cyc = 0;
  always @(negedge clk) begin
    int ex, ey;
    logic [11:0] ecol;
    if (frame_no != mon_frame) begin
      mon_frame = frame_no;
      k = 0;
    end
    if (lost) begin
      lost_cnt++;
      lost_cyc = cyc;
    end
    if (crc_valid) crcv_cnt++;
    if (pix_valid) begin
      ex = k % HA;
      ey = k / HA;
      ecol = solid ? 12'hF0A : {4'(ex), 4'(ey), 4'h5};
      if (pix_x !== 10'(ex) || pix_y !== 10'(ey) || pix_rgb !== ecol ||
          pix_sof !== (k == 0) || pix_eol !== (ex == HA - 1)) mon_bad++;
      if (pix_sof) sof_cyc = cyc;
      k++;
      mon_pix++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic hs, input logic vs, input logic [11:0] col);
    hsync_n = ~hs;
    vsync_n = ~vs;
    hsync_p = hs;
    vsync_p = vs;
    {r, g, b} = col;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
    chk({tag, "_pix_xy"}, 32'({pix_x, pix_y}), 0);
    chk({tag, "_pix_misc"}, 32'({pix_rgb, pix_sof, pix_eol}), 0);
    chk({tag, "_line_len"}, 32'(line_len), 0);
    chk({tag, "_frame_lines"}, 32'(frame_lines), 0);
    chk({tag, "_locked_lost"}, 32'({locked, lost}), 0);
    chk({tag, "_frame_crc"}, 32'(frame_crc), 32'(CRC_RST));
    chk({tag, "_crc_valid"}, 32'(crc_valid), 0);
  endtask

  // One frame: hsync active 2 clks at line start, vsync active lines 0-1
  task automatic run_frame(input int bad_line, input int rst_line);
    int len, x, y;
    logic [11:0] col;
    frame_no++;
    for (int ln = 0; ln < NL; ln++) begin
      len = (ln == bad_line) ? LL + 1 : LL;
      for (int c = 0; c < len; c++) begin
        x = c - HS;
        y = ln - VS;
        if (solid) col = 12'hF0A;
        else if (x >= 0 && x < HA && y >= 0 && y < VA) col = {4'(x), 4'(y), 4'h5};
        else col = 12'h000;
        if (c == 0) last_hs_cyc = cyc;
        if (ln == VS && c == HS) first_pix_cyc = cyc;
        rst = (ln == rst_line && c == 6);
        drive(c < 2, ln < 2, col);
        if (rst) begin
          chk_reset_state("midframe_rst");
          rst = 1'b0;
        end
      end
    end
  endtask

  function automatic logic [15:0] crc_ref(input int n, input logic [11:0] d);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int p = 0; p < n; p++)
      for (int i = 11; i >= 0; i--) begin
        fb = c[15] ^ d[i];
        c = c << 1;
        if (fb) c = c ^ 16'h1021;
      end
    return c;
  endfunction

  initial begin
    int p0, l0, c0;
    logic [15:0] exp_crc;
    rst = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 12'h000);
    chk_reset_state("in_rst");
    rst = 1'b0;
    drive(1'b0, 1'b0, 12'h000);
    chk_reset_state("after_rst");
    repeat (5) drive(1'b0, 1'b0, 12'h000);

    // Lock acquisition over three frames
    run_frame(-1, -1);
    run_frame(-1, -1);
    chk("no_lock_after_2_vsync", 32'(locked), 0);
    chk("no_pix_before_lock", 32'(mon_pix), 0);
    p0 = mon_pix;
    run_frame(-1, -1);
    chk("locked_3rd_vsync", 32'(locked), 1);
    chk("line_len", 32'(line_len), 32'(LL));
    chk("frame_lines", 32'(frame_lines), 32'(NL));
    chk("pix_count_f3", 32'(mon_pix - p0), 32'(HA * VA));
    chk("pix_latency", 32'(sof_cyc - first_pix_cyc), 2);
    chk("pos_locked", 32'(p_locked), 1);
    chk("pos_line_len", 32'(p_line_len), 32'(LL));
    chk("pos_frame_lines", 32'(p_frame_lines), 32'(NL));

    // One 21-clk line while locked
    l0 = lost_cnt;
    run_frame(4, -1);
    chk("still_locked_bad_frame", 32'(locked), 1);
    run_frame(-1, -1);
    chk("lost_on_mismatch", 32'(lost_cnt - l0), 1);
    chk("unlocked_after_mismatch", 32'(locked), 0);
    run_frame(-1, -1);
    chk("no_relock_1_frame", 32'(locked), 0);
    p0 = mon_pix;
    run_frame(-1, -1);
    chk("relock_2_frames", 32'(locked), 1);
    chk("pix_count_relock", 32'(mon_pix - p0), 32'(HA * VA));

    // hsync missing for 5000 clocks
    l0 = lost_cnt;
    p0 = mon_pix;
    repeat (5000) drive(1'b0, 1'b0, 12'h000);
    chk("timeout_lost_once", 32'(lost_cnt - l0), 1);
    chk("timeout_cycle", 32'(lost_cyc - last_hs_cyc), 4097);
    chk("timeout_unlocked", 32'(locked), 0);
    chk("timeout_no_pix", 32'(mon_pix - p0), 0);
    run_frame(-1, -1);
    run_frame(-1, -1);
    chk("no_lock_after_timeout", 32'(locked), 0);
    run_frame(-1, -1);
    chk("relock_after_timeout", 32'(locked), 1);

    // Reset in the middle of a locked frame
    run_frame(-1, 3);
    chk("unlocked_after_rst", 32'(locked), 0);
    run_frame(-1, -1);
    run_frame(-1, -1);
    chk("no_lock_2_after_rst", 32'(locked), 0);
    run_frame(-1, -1);
    chk("relock_after_rst", 32'(locked), 1);

    // Solid colour frames for the frame CRC
    solid = 1'b1;
    c0 = crcv_cnt;
    run_frame(-1, -1);
    run_frame(-1, -1);
`ifdef FRAME_CRC_EN
    exp_crc = crc_ref(HA * VA, 12'hF0A);
`else
    exp_crc = 16'h0000;
`endif
    chk("frame_crc_1", 32'(frame_crc), 32'(exp_crc));
    run_frame(-1, -1);
    chk("frame_crc_2", 32'(frame_crc), 32'(exp_crc));
`ifdef FRAME_CRC_EN
    chk("crc_valid_count", 32'(crcv_cnt - c0), 3);
`else
    chk("crc_valid_count", 32'(crcv_cnt - c0), 0);
`endif
    chk("pixel_content", 32'(mon_bad), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
